mod_n_updown: RTL and testbench
===============================

# mod_n_updown

Run-time programmable modulo-M up/down counter, parametrised by the largest supported modulus N_MAX. It generalises the fixed mod-N counter with direction control, count enable, synchronous load, a run-time modulus that is applied only at safe points, and a combinational terminal-count output for cascading stages into multi-digit counters and dividers. It sits in the timing/divider datapath and is clocked by the system clock.

## Interface
Parameters:
- N_MAX, default 17: largest modulus supported; must be ≥ 2.
- WIDTH, default $clog2(N_MAX): count width. Derived; not overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded on load.
- mod_val  input  WIDTH+1  requested modulus M.
- count  output  WIDTH  current count, always in 0..M_act-1.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse; count wrapped in the previous cycle.
- cfg_err  output  1  sticky flag; an illegal mod_val was captured.

## Operation
- Internal register M_act (WIDTH+1 bits) holds the active modulus.
- Legal modulus: 2 ≤ mod_val ≤ N_MAX. An illegal value is replaced by N_MAX when captured, and cfg_err is set to 1. cfg_err clears only on reset.
- M_act captures the (sanitised) mod_val on a load cycle, or on a wrap step. At no other time; mid-count changes to mod_val have no effect until the next capture.
- Per-cycle priority: load > en > hold.
  - load=1: M_act is captured; count ← load_val if load_val < new M_act, otherwise 0. wrap ← 0. The en and up_dn inputs are ignored in this cycle.
  - load=0, en=1, up_dn=1: if count = M_act-1, then count ← 0, wrap ← 1, and M_act is captured. Otherwise count ← count+1 and wrap ← 0.
  - load=0, en=1, up_dn=0: if count = 0, then M_act is captured first and count ← new M_act-1, wrap ← 1. Otherwise count ← count-1 and wrap ← 0.
  - load=0, en=0: count holds, wrap ← 0.
- tc = en & ~load & (up_dn ? count = M_act-1 : count = 0). Cascading uses tc of stage k as en of stage k+1.
- Arithmetic is done at WIDTH+1 bits. No intermediate value may overflow, including at M_act = N_MAX = 2^WIDTH.
- Direction may change on any cycle. The step uses the up_dn value sampled in that cycle; there is no pipeline penalty.

## Timing
- Reset (rst=0): asynchronous. count=0, wrap=0, cfg_err=0, M_act=N_MAX. These take effect immediately, without a clock.
- Reset release: synchronous to clk. The first count step occurs on the first rising edge with rst=1 and en=1.
- Reset mid-count: the count is lost, and any pending modulus change is discarded (M_act=N_MAX).
- count latency: the value at edge t+1 reflects the inputs at edge t.
- wrap: high for exactly one cycle, in the cycle after the wrapping edge, aligned with count = 0 (up) or count = M_act-1 (down). Back-to-back wraps are possible when M_act = 2 and en is held high.
- tc: same-cycle combinational. It must not depend on wrap or on any registered lookahead.
- M = N_MAX, up direction: the sequence is 0..N_MAX-1, then 0.
- M = 2: the sequence alternates 0, 1, 0, … with tc high on every 1.

## Test plan
- Reset and free-run: N_MAX=17, mod_val=17, en=1, up_dn=1, hold rst=0 for 10 ns, then release. count runs 0..16 then 0. wrap is high only on the cycle with count=0 after 16. tc is high whenever count=16.
- Down count and direction change: count reaches 5, then set up_dn=0. The sequence is 4, 3, 2, 1, 0, 16 with wrap on 16. Then set up_dn=1 at 16; the next value is 0 with wrap.
- Deferred modulus: while count=3 with M_act=17, set mod_val=10. Counting continues to 16 and wraps to 0. The next wrap then occurs after 9 (0..9).
- Load and priority: load=1 with en=1, load_val=7, mod_val=12 gives count=7, wrap=0, M_act=12. A subsequent load_val=15 with mod_val=12 gives count=0.
- Illegal modulus: load with mod_val=1 gives M_act=17 and cfg_err=1. cfg_err stays 1 after a later legal load, and clears only when rst=0.
- Async reset mid-count plus cascade: two instances chained (tc→en), 30 cycles. Assert rst=0 between clock edges; both counts read 0 before the next edge. Stage 2 increments exactly once per stage-1 wrap.

Source files
------------

// File: rtl/mod_n_updown.sv
// Run-time programmable modulo-M up/down counter with cascade terminal count.
// The active modulus is only changed at safe points (load or wrap) so a
// divider chain never sees a truncated or stretched period mid-count.
module mod_n_updown #(
    parameter int N_MAX = 17,
    parameter int WIDTH = $clog2(N_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH:0]   mod_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             cfg_err
);

    // All modulus arithmetic is one bit wider than the count so that
    // M_act = N_MAX = 2^WIDTH is representable.
    localparam logic [WIDTH:0] N_MAX_M = (WIDTH+1)'(N_MAX);
    localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] TWO     = (WIDTH+1)'(2);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH:0]   m_act_q, m_act_d;
    logic             wrap_q, wrap_d;
    logic             cfg_err_q, cfg_err_d;

    logic             mod_legal;
    logic [WIDTH:0]   mod_san;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   m_last;
    logic [WIDTH-1:0] new_last;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;
    logic             at_top;
    logic             at_zero;
    logic             load_fits;
    logic             capture;

    // Sanitise the requested modulus and precompute the compare/step values.
    always_comb begin
        mod_legal = (mod_val >= TWO) && (mod_val <= N_MAX_M);
        mod_san   = mod_legal ? mod_val : N_MAX_M;
        count_ext = {1'b0, count_q};
        m_last    = m_act_q - ONE;
        // The results below never need the extra bit: count+1 <= N_MAX and
        // the decrement is only used when count is non-zero.
        new_last  = WIDTH'(mod_san - ONE);
        count_inc = WIDTH'(count_ext + ONE);
        count_dec = WIDTH'(count_ext - ONE);
        at_top    = (count_ext == m_last);
        at_zero   = (count_q == '0);
        load_fits = ({1'b0, load_val} < mod_san);
    end

    // Next-state logic: load has priority over counting, counting over hold.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        count_d   = count_q;
        m_act_d   = m_act_q;
        wrap_d    = 1'b0;
        cfg_err_d = cfg_err_q;
        capture   = 1'b0;

        if (load) begin
            capture = 1'b1;
            count_d = load_fits ? load_val : '0;
        end else if (en) begin
            if (up_dn) begin
                if (at_top) begin
                    capture = 1'b1;
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end else begin
                if (at_zero) begin
                    // The new modulus is captured first, so the count lands on
                    // the top of the new range rather than the old one.
                    capture = 1'b1;
                    count_d = new_last;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_dec;
                end
            end
        end

        if (capture) begin
            m_act_d   = mod_san;
            cfg_err_d = cfg_err_q | ~mod_legal;
        end
    end

    // State registers; reset discards any pending modulus change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            m_act_q   <= N_MAX_M;
            wrap_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            count_q   <= count_d;
            m_act_q   <= m_act_d;
            wrap_q    <= wrap_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // tc is purely combinational from the current count and inputs so a
    // cascaded stage steps on the same edge that this stage wraps.
    assign tc      = en & ~load & (up_dn ? at_top : at_zero);
    assign count   = count_q;
    assign wrap    = wrap_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_mod_n_updown.sv
// Scoreboard bench for mod_n_updown: a driver applies directed vectors on the
// falling edge and queues the hand-derived response; a monitor pops and
// compares shortly after each falling edge. A second instance is cascaded on
// tc to exercise multi-digit counting.
module tb_mod_n_updown;

    localparam int N_MAX = 17;
    localparam int W     = $clog2(N_MAX);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b1;
    logic         up_dn = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W:0]   mod_val = (W+1)'(N_MAX);
    logic [W-1:0] count;
    logic         tc;
    logic         wrap;
    logic         cfg_err;

    logic [W-1:0] hi_count;
    logic         hi_tc;
    logic         hi_wrap;
    logic         hi_err;

    mod_n_updown #(.N_MAX(N_MAX)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .mod_val  (mod_val),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .cfg_err  (cfg_err)
    );

    mod_n_updown #(.N_MAX(N_MAX)) u_hi (
        .clk      (clk),
        .rst      (rst),
        .en       (tc),
        .up_dn    (1'b1),
        .load     (1'b0),
        .load_val ('0),
        .mod_val  ((W+1)'(N_MAX)),
        .count    (hi_count),
        .tc       (hi_tc),
        .wrap     (hi_wrap),
        .cfg_err  (hi_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        int   cnt;
        logic tc;
        logic wrap;
        logic err;
        logic ck_hi;
        int   hi;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   step_no = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // One cycle of stimulus plus the response expected during that cycle.
    task automatic cyc(input logic i_en, input logic i_up, input logic i_ld,
                       input int i_lv, input int i_mv,
                       input int e_cnt, input logic e_tc, input logic e_wrap,
                       input logic e_err, input logic ck_hi, input int e_hi);
        exp_t e;
        @(negedge clk);
        rst      = 1'b1;
        en       = i_en;
        up_dn    = i_up;
        load     = i_ld;
        load_val = W'(i_lv);
        mod_val  = (W+1)'(i_mv);
        e.idx   = step_no;
        e.cnt   = e_cnt;
        e.tc    = e_tc;
        e.wrap  = e_wrap;
        e.err   = e_err;
        e.ck_hi = ck_hi;
        e.hi    = e_hi;
        q.push_back(e);
        step_no++;
    endtask

    // Monitor: compares the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        #2;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_vec++;
            check("count",   mon_e.idx, 32'(count),   32'(mon_e.cnt));
            check("tc",      mon_e.idx, 32'(tc),      32'(mon_e.tc));
            check("wrap",    mon_e.idx, 32'(wrap),    32'(mon_e.wrap));
            check("cfg_err", mon_e.idx, 32'(cfg_err), 32'(mon_e.err));
            if (mon_e.ck_hi)
                check("hi_count", mon_e.idx, 32'(hi_count), 32'(mon_e.hi));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, before any clock edge.
        #2;
        n_vec++;
        check("rst_count",   -1, 32'(count),   32'd0);
        check("rst_wrap",    -1, 32'(wrap),    32'd0);
        check("rst_cfg_err", -1, 32'(cfg_err), 32'd0);

        // Free-run up, M=17: 0..16 then 0 with wrap.
        for (int i = 0; i < 18; i++)
            cyc(1, 1, 0, 0, 17, i % 17, (i % 17) == 16, i == 17, 0, 0, 0);

        // Count to 5, then down through 0 to 16, then back up.
        for (int c = 1; c <= 4; c++)
            cyc(1, 1, 0, 0, 17, c, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 17, 5, 0, 0, 0, 0, 0);
        for (int c = 4; c >= 1; c--)
            cyc(1, 0, 0, 0, 17, c, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 17, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 17, 16, 1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 17, 0, 0, 1, 0, 0, 0);

        // Deferred modulus: mod_val=10 requested at count 3, active after wrap.
        cyc(1, 1, 0, 0, 17, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 17, 2, 0, 0, 0, 0, 0);
        for (int c = 3; c <= 16; c++)
            cyc(1, 1, 0, 0, 10, c, c == 16, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 10, 0, 0, 1, 0, 0, 0);
        for (int c = 1; c <= 9; c++)
            cyc(1, 1, 0, 0, 10, c, c == 9, 0, 0, 0, 0);

        // Load beats en; load_val=7 with M=12, then hold, then count to wrap.
        cyc(1, 1, 1, 7, 12, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 7, 12, 7, 0, 0, 0, 0, 0);
        for (int c = 7; c <= 11; c++)
            cyc(1, 1, 0, 0, 12, c, c == 11, 0, 0, 0, 0);
        // Out-of-range load_val=15 with M=12 loads 0; then step down to 11.
        cyc(1, 1, 1, 15, 12, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 12, 0, 1, 0, 0, 0, 0);

        // Illegal modulus: mod_val=1 becomes 17 and sets sticky cfg_err.
        cyc(1, 1, 1, 16, 1, 11, 0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 16, 1, 0, 1, 0, 0);
        cyc(1, 1, 1, 3, 5, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 5, 3, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 5, 4, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 5, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 5, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 5, 1, 0, 0, 1, 0, 0);

        // Asynchronous reset between edges, mid-count.
        @(posedge clk);
        #1;
        n_vec++;
        check("pre_rst_count", -2, 32'(count), 32'd2);
        #1 rst = 1'b0;
        #1;
        n_vec++;
        check("async_count",    -2, 32'(count),    32'd0);
        check("async_hi_count", -2, 32'(hi_count), 32'd0);
        check("async_cfg_err",  -2, 32'(cfg_err),  32'd0);
        check("async_wrap",     -2, 32'(wrap),     32'd0);

        // Cascade: M_act restarts at 17 despite the earlier M=5 and the
        // pending mod_val=4; after the first wrap the period is 4. The upper
        // stage counts stage-1 wraps.
        for (int j = 0; j < 30; j++) begin
            int   e_cnt;
            logic e_tc;
            logic e_wr;
            int   e_hi;
            if (j < 17) begin
                e_cnt = j;
                e_tc  = (j == 16);
                e_wr  = 1'b0;
                e_hi  = 0;
            end else begin
                e_cnt = (j - 17) % 4;
                e_tc  = (e_cnt == 3);
                e_wr  = (e_cnt == 0);
                e_hi  = 1 + (j - 17) / 4;
            end
            cyc(1, 1, 0, 0, 4, e_cnt, e_tc, e_wr, 0, 1, e_hi);
        end

        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 10 && q.size() != 0; k++)
            @(negedge clk);
        #3;
        n_vec++;
        check("drain", -3, 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
